// File: rtl/serial_sched_pkg.sv
// Shared types and sizing helpers for serial_word_sched.
package serial_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int WIDTH_DEF = 8;
  localparam int GAP_DEF   = 1;
  // Counter width for the default configuration; the top recomputes it
  // from its own parameters via cnt_w().
  localparam int CNT_W     = $clog2(WIDTH_DEF + GAP_DEF);
  localparam int HITCNT_W  = 4;

  // Down-counter width able to hold WIDTH-1 and GAP-1.
  function automatic int cnt_w(input int width, input int gap);
    return (width + gap <= 2) ? 1 : $clog2(width + gap);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant. Purely combinational; the caller keeps 'last'
// (the most recent winner) and updates it on each accepted request.
module rr_arb2 (
  input  logic       valid0,
  input  logic       valid1,
  input  logic       last,
  output logic [1:0] grant
);

  // A lone requester wins; under contention the requester that is not 'last' wins.
  always_comb begin
    grant = 2'b00;
    if (valid0 && (!valid1 || last)) grant = 2'b01;
    else if (valid1)                 grant = 2'b10;
  end

endmodule

// File: rtl/serial_word_sched.sv
// Word sequencer and two-client arbiter in front of the serial pattern
// detector. Accepts a word, shifts it LSB-first on serial_out, drains GAP
// zero cycles, then reports whether det_i fired during the word's window.
// Optional per-client saturating hit counters: SERIAL_SCHED_HITCNT_EN.
module serial_word_sched
  import serial_sched_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int GAP   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic             serial_out,
  input  logic             det_i,
  output logic             busy,
  output logic             done_valid,
  output logic             done_src,
  output logic             done_hit
`ifdef SERIAL_SCHED_HITCNT_EN
  ,
  output logic [HITCNT_W-1:0] hit_cnt0,
  output logic [HITCNT_W-1:0] hit_cnt1
`endif
);

  localparam int CW = cnt_w(WIDTH, GAP);

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] shreg;
  logic             hit;
  logic             last;
  logic [1:0]       grant;
  logic             hs;
  logic             cnt_zero;
  logic [WIDTH-1:0] word;

  rr_arb2 u_arb (
    .valid0 (req0_valid),
    .valid1 (req1_valid),
    .last   (last),
    .grant  (grant)
  );

  assign cnt_zero = (cnt == '0);
  assign hs       = req0_ready | req1_ready;
  assign word     = req1_ready ? req1_data : req0_data;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state: IDLE -> SHIFT on accept, SHIFT -> DRAIN after the last bit,
  // DRAIN -> IDLE after GAP cycles.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (hs)       state_nxt = SHIFT;
      SHIFT:   if (cnt_zero) state_nxt = DRAIN;
      DRAIN:   if (cnt_zero) state_nxt = IDLE;
      default:               state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state: ready only in IDLE (and never during reset).
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    busy       = (state != IDLE);
    if (state == IDLE && reset) {req1_ready, req0_ready} = grant;
  end

  // Datapath: shift register, bit counter, hit flag, owner and completion.
  // serial_out is loaded with bit 0 at the accept edge so bit i is visible
  // in the cycle after edge N+i; shreg then holds the bits still to come.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg      <= '0;
      cnt        <= '0;
      serial_out <= 1'b0;
      hit        <= 1'b0;
      last       <= 1'b1;
      done_valid <= 1'b0;
      done_src   <= 1'b0;
      done_hit   <= 1'b0;
    end else begin
      done_valid <= 1'b0;
      case (state)
        IDLE: if (hs) begin
          shreg      <= word >> 1;
          serial_out <= word[0];
          cnt        <= CW'(WIDTH - 1);
          hit        <= 1'b0;
          last       <= req1_ready;
        end
        SHIFT: begin
          hit <= hit | det_i;
          if (cnt_zero) begin
            serial_out <= 1'b0;
            cnt        <= CW'(GAP - 1);
          end else begin
            serial_out <= shreg[0];
            shreg      <= shreg >> 1;
            cnt        <= cnt - 1'b1;
          end
        end
        DRAIN: begin
          hit <= hit | det_i;
          if (cnt_zero) begin
            // Fold in det_i from this final edge so a late detection counts.
            done_valid <= 1'b1;
            done_src   <= last;
            done_hit   <= hit | det_i;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SERIAL_SCHED_HITCNT_EN
  logic fin;
  assign fin = (state == DRAIN) && cnt_zero && (hit || det_i);

  // Saturating hit counters, updated together with the done pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hit_cnt0 <= '0;
      hit_cnt1 <= '0;
    end else if (fin) begin
      if (!last && hit_cnt0 != '1) hit_cnt0 <= hit_cnt0 + 1'b1;
      if ( last && hit_cnt1 != '1) hit_cnt1 <= hit_cnt1 + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_serial_word_sched.sv
// Scoreboard bench for serial_word_sched: a word-level reference model
// predicts serial bits, readies and completions; a negedge monitor compares.
module tb_serial_word_sched;
  localparam int W = 8;
  localparam int G = 1;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         req0_valid = 1'b0, req1_valid = 1'b0;
  logic [W-1:0] req0_data = '0, req1_data = '0;
  logic         req0_ready, req1_ready;
  logic         serial_out, det_i = 1'b0, busy;
  logic         done_valid, done_src, done_hit;
`ifdef SERIAL_SCHED_HITCNT_EN
  logic [3:0]   hit_cnt0, hit_cnt1;
`endif

  always #5 clk = ~clk;

  serial_word_sched #(.WIDTH(W), .GAP(G)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .serial_out(serial_out), .det_i(det_i), .busy(busy),
    .done_valid(done_valid), .done_src(done_src), .done_hit(done_hit)
`ifdef SERIAL_SCHED_HITCNT_EN
    , .hit_cnt0(hit_cnt0), .hit_cnt1(hit_cnt1)
`endif
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Arbitration rule: lone requester wins, contention goes to the non-last one.
  function automatic int winner(input logic v0, input logic v1, input int lst);
    if (v0 && v1) return (lst == 1) ? 0 : 1;
    if (v0) return 0;
    if (v1) return 1;
    return -1;
  endfunction

  // ---------------- reference model ----------------
  typedef struct { int src; int hit; } done_t;
  int      rem, m_last, m_owner, exp_ser, m_cnt0, m_cnt1, w;
  bit      m_hit;
  bit      ser_q[$];
  done_t   done_q[$];
  logic [W-1:0] md;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      rem = 0; m_last = 1; m_owner = 0; m_hit = 0; exp_ser = 0;
      m_cnt0 = 0; m_cnt1 = 0;
      ser_q.delete(); done_q.delete();
    end else begin
      if (rem > 0) begin
        m_hit = m_hit | det_i;
        rem--;
        if (rem == 0) begin
          done_q.push_back('{m_owner, int'(m_hit)});
          if (m_hit && m_owner == 0 && m_cnt0 < 15) m_cnt0++;
          if (m_hit && m_owner == 1 && m_cnt1 < 15) m_cnt1++;
        end
      end else begin
        w = winner(req0_valid, req1_valid, m_last);
        if (w >= 0) begin
          m_last = w; m_owner = w; m_hit = 0; rem = W + G;
          md = (w == 1) ? req1_data : req0_data;
          for (int i = 0; i < W; i++) ser_q.push_back(md[i]);
          for (int i = 0; i < G; i++) ser_q.push_back(1'b0);
        end
      end
      exp_ser = (ser_q.size() > 0) ? int'(ser_q.pop_front()) : 0;
    end
  end

  // ---------------- monitor ----------------
  done_t dx;
  int    ew;
  always @(negedge clk) begin
    ew = (reset && rem == 0) ? winner(req0_valid, req1_valid, m_last) : -1;
    chk("ready0", req0_ready, (ew == 0));
    chk("ready1", req1_ready, (ew == 1));
    chk("serial_out", serial_out, exp_ser);
    chk("busy", busy, (rem != 0));
    chk("done_valid", done_valid, (done_q.size() > 0));
    if (done_valid && done_q.size() > 0) begin
      dx = done_q.pop_front();
      chk("done_src", done_src, dx.src);
      chk("done_hit", done_hit, dx.hit);
    end
`ifdef SERIAL_SCHED_HITCNT_EN
    chk("hit_cnt0", hit_cnt0, m_cnt0);
    chk("hit_cnt1", hit_cnt1, m_cnt1);
`endif
  end

  task automatic chk_reset_vals();
    chk("rst_serial", serial_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done_valid", done_valid, 0);
    chk("rst_done_src", done_src, 0);
    chk("rst_done_hit", done_hit, 0);
    chk("rst_ready0", req0_ready, 0);
    chk("rst_ready1", req1_ready, 0);
  endtask

  // Offer one word from req0 for a single accepting edge.
  task automatic send0(input logic [W-1:0] d);
    @(posedge clk); #1 req0_valid = 1'b1; req0_data = d;
    @(posedge clk); #1 req0_valid = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    req1_valid = 1'b1;           // readies must stay 0 under reset
    repeat (3) @(posedge clk);
    #1 chk_reset_vals();
    req1_valid = 1'b0;
    @(posedge clk); #2 reset = 1'b1;

    // Lone client 0, det low.
    send0(8'hC5);
    repeat (12) @(posedge clk);

    // Same word, det pulsed on the final drain edge (N+9).
    send0(8'hC5);
    repeat (8) @(posedge clk);
    #1 det_i = 1'b1;
    @(posedge clk); #1 det_i = 1'b0;
    @(negedge clk);
    chk("late_det_hit", done_hit, 1);
    repeat (4) @(posedge clk);

    // Continuous contention: grants alternate, spacing W+G+1.
    @(posedge clk); #1 req0_valid = 1'b1; req1_valid = 1'b1;
    req0_data = 8'h01; req1_data = 8'h80;
    repeat (45) @(posedge clk);
    #1 req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (12) @(posedge clk);

    // Async reset after bit 3 of a word; then contention must go to client 0.
    send0(8'h5A);
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    #1 chk_reset_vals();
    @(posedge clk); #2 reset = 1'b1;
    #1 req0_valid = 1'b1; req1_valid = 1'b1;
    @(negedge clk);
    chk("post_reset_grant0", req0_ready, 1);
    @(posedge clk); #1 req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (12) @(posedge clk);

    // req1 wiggles valid/data while a word shifts.
    send0(8'h96);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1 req1_valid = i[0]; req1_data = W'($urandom);
    end
    #0 req1_valid = 1'b0;
    repeat (12) @(posedge clk);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      req0_valid = ($urandom_range(0, 3) != 0);
      req1_valid = ($urandom_range(0, 2) != 0);
      req0_data  = W'($urandom);
      req1_data  = W'($urandom);
      det_i      = ($urandom_range(0, 15) == 0);
    end
    #0 req0_valid = 1'b0; req1_valid = 1'b0; det_i = 1'b0;
    repeat (12) @(posedge clk);

`ifdef SERIAL_SCHED_HITCNT_EN
    // 17 hits from client 0 saturate its counter.
    #2 reset = 1'b0;
    @(posedge clk); #2 reset = 1'b1;
    #1 req0_valid = 1'b1; req0_data = 8'h33; det_i = 1'b1;
    repeat (17 * (W + G + 1) - 3) @(posedge clk);
    #1 req0_valid = 1'b0;
    repeat (12) @(posedge clk);
    #1 det_i = 1'b0;
    chk("sat_cnt0", hit_cnt0, 15);
    chk("sat_cnt1", hit_cnt1, 0);
`endif

    repeat (5) @(posedge clk);
    chk("done_q_empty", done_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
